// File: rtl/dma_ctrl.sv
// dma_ctrl: sprite-style DMA engine that copies LEN bytes from a 256-byte
// source page to a single fixed destination address (OAM_ADDR).
// A CPU write of the page number to TRIG_ADDR starts a transfer. While a
// transfer runs, the CPU is stalled and the engine owns the memory bus.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous reset, active low
//   cpu_addr  CPU bus address           (ignored while busy)
//   cpu_din   CPU write data            (ignored while busy)
//   cpu_we    CPU write enable          (ignored while busy)
//   cpu_dout  read data to the CPU, 8'h00 while busy or writing
//   cpu_rdy   1 = CPU owns memory, 0 = CPU stalled
//   mem_addr  shared memory address
//   mem_din   shared memory write data
//   mem_we    shared memory write enable
//   mem_dout  shared memory read data (combinational from mem_addr)
//   dma_busy  high in every non-IDLE state
//   dma_done  one-cycle pulse in the first IDLE cycle after the last write
module dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004,
  parameter int          LEN       = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  output logic [7:0]  cpu_dout,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    ALIGN2 = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4
  } state_t;

  // idx is 8 bits, so LEN=256 terminates at 8'hFF.
  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  state_t     state, state_next;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] latch;
  logic       parity;
  logic       odd_start;
  logic       done;
  logic       trig;
  logic       last;

  assign trig     = (state == IDLE) && cpu_we && (cpu_addr == TRIG_ADDR);
  assign last     = (idx == LAST_IDX);
  assign dma_busy = (state != IDLE);
  assign dma_done = done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      page      <= 8'h00;
      idx       <= 8'h00;
      latch     <= 8'h00;
      parity    <= 1'b0;
      odd_start <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= state_next;
      parity <= ~parity;
      // Pulse lands in the IDLE cycle that follows the final write.
      done   <= (state == WRITE) && last;
      case (state)
        IDLE: begin
          if (trig) begin
            page      <= cpu_din;
            idx       <= 8'h00;
            // Parity seen at the trigger edge decides the extra align cycle.
            odd_start <= parity;
          end
        end
        READ:  latch <= mem_dout;
        WRITE: begin
          // Address stays {page,idx}; idx never carries into page.
          if (!last) idx <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    mem_addr   = 16'h0000;
    mem_din    = 8'h00;
    mem_we     = 1'b0;
    cpu_dout   = 8'h00;
    cpu_rdy    = 1'b0;
    case (state)
      IDLE: begin
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
        // State is already IDLE during reset; gating keeps memory untouched.
        mem_we   = cpu_we & reset_n;
        cpu_dout = cpu_we ? 8'h00 : mem_dout;
        cpu_rdy  = 1'b1;
        if (trig) state_next = ALIGN;
      end
      ALIGN:  state_next = odd_start ? ALIGN2 : READ;
      ALIGN2: state_next = READ;
      READ: begin
        mem_addr   = {page, idx};
        state_next = WRITE;
      end
      WRITE: begin
        mem_addr   = OAM_ADDR;
        mem_din    = latch;
        mem_we     = 1'b1;
        state_next = last ? IDLE : READ;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
